// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling 8N1 receiver that collects fixed-length frames into a readable buffer
// Ports:
//   clk         receiver clock, OVS x baudrate
//   reset       asynchronous active-low reset
//   rx          serial line, idle high
//   rd_addr     frame buffer read address
//   rd_data     buffer[rd_addr], registered, 1-cycle latency
//   byte_valid  one-clock pulse, new byte stored
//   byte_data   last received byte, held until next byte
//   wptr        index of next byte slot in current frame
//   frame_done  one-clock pulse, BYTES bytes received
//   frame_cnt   completed frames, wraps 255->0
//   stop_err    one-clock pulse, stop bit sampled low
//   short_frame one-clock pulse, partial frame aborted by idle gap
module uart_rx_frame #(
  parameter int OVS   = 4,
  parameter int BYTES = 20,
  parameter int GAP   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic [4:0] wptr,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       stop_err,
  output logic       short_frame
);
  localparam int CW = $clog2(OVS);
  localparam int GW = $clog2(GAP);
  localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVS - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);
  localparam logic [4:0] LASTB = 5'(BYTES - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
  state_t state, nstate;
  logic [1:0] sync;
  logic rxs;
  logic [CW-1:0] cnt, ncnt;
  logic [2:0] bidx, nbidx;
  logic [7:0] shift;
  logic [GW-1:0] gap;
  logic [7:0] mem [32];
  logic shift_en, take, bad, abort, last;
  assign rxs   = sync[1];
  assign last  = wptr == LASTB;
  assign abort = state == IDLE && rxs && wptr != '0 && gap == GLAST;
  always_comb begin
    nstate   = state;
    ncnt     = cnt + 1'b1;
    nbidx    = bidx;
    shift_en = 1'b0;
    take     = 1'b0;
    bad      = 1'b0;
    case (state)
      IDLE: begin
        ncnt = '0;
        nstate = rxs ? IDLE : START;
      end
      START: if (cnt == HALF) begin
        ncnt = '0;
        nbidx = '0;
        nstate = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        ncnt = '0;
        shift_en = 1'b1;
        nbidx = bidx + 1'b1;
        nstate = bidx == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        ncnt = '0;
        take = rxs;
        bad = !rxs;
        nstate = rxs ? IDLE : WAITHI;
      end
      WAITHI: begin
        ncnt = '0;
        nstate = rxs ? IDLE : WAITHI;
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync        <= 2'b11;
      state       <= IDLE;
      cnt         <= '0;
      bidx        <= '0;
      shift       <= '0;
      gap         <= '0;
      wptr        <= '0;
      frame_cnt   <= '0;
      byte_data   <= '0;
      rd_data     <= '0;
      byte_valid  <= 1'b0;
      frame_done  <= 1'b0;
      stop_err    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      sync        <= {sync[0], rx};
      state       <= nstate;
      cnt         <= ncnt;
      bidx        <= nbidx;
      rd_data     <= mem[rd_addr];
      byte_valid  <= take;
      frame_done  <= take && last;
      stop_err    <= bad;
      short_frame <= abort;
      if (shift_en) shift <= {rxs, shift[7:1]};
      if (take) begin
        byte_data <= shift;
        wptr      <= last ? '0 : wptr + 1'b1;
        if (last) frame_cnt <= frame_cnt + 1'b1;
      end else if (abort) wptr <= '0;
      gap <= (!rxs || wptr == '0 || abort) ? '0 : state == IDLE ? gap + 1'b1 : gap;
    end
  always_ff @(posedge clk)
    if (take) mem[wptr] <= shift;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed table-driven bench for uart_rx_frame
module tb_uart_rx_frame;
  localparam int OVS = 4, BYTES = 20, GAP = 64;
  logic clk = 0, reset = 0, rx = 1;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_data, byte_data, frame_cnt;
  logic [4:0] wptr;
  logic byte_valid, frame_done, stop_err, short_frame;
  int passed = 0, total = 0;
  int nbv = 0, nerr = 0, nshort = 0, nfd = 0, ncoin = 0, ncoll = 0, cyc = 0, t_bv = 0, t_sh = 0;

  uart_rx_frame #(.OVS(OVS), .BYTES(BYTES), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .wptr(wptr), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .stop_err(stop_err), .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (byte_valid === 1'b1) begin nbv++; t_bv = cyc; end
    if (stop_err === 1'b1) nerr++;
    if (frame_done === 1'b1) nfd++;
    if (frame_done === 1'b1 && byte_valid === 1'b1) ncoin++;
    if (frame_done === 1'b1 && short_frame === 1'b1) ncoll++;
    if (short_frame === 1'b1) begin nshort++; t_sh = cyc; end
  end

  typedef struct {
    logic [7:0] d;
    logic       ok;
    int         ev;
    int         ee;
    logic [7:0] ed;
    logic [4:0] ew;
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic ok);
    drive(1'b0, OVS);
    for (int i = 0; i < 8; i++) drive(d[i], OVS);
    if (!ok) drive(1'b0, 12);
    drive(1'b1, OVS);
  endtask

  initial begin
    int b0, e0, f0, c0, s0, k;
    tv[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5, 5'd1};
    tv[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5, 5'd1};
    tv[2] = '{8'h55, 1'b1, 1, 0, 8'h55, 5'd2};
    tv[3] = '{8'h00, 1'b1, 1, 0, 8'h00, 5'd3};
    tv[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF, 5'd4};
    tv[5] = '{8'h81, 1'b1, 1, 0, 8'h81, 5'd5};
    repeat (3) @(posedge clk);
    #1;
    chk("reset byte_data", int'(byte_data), 0);
    chk("reset wptr", int'(wptr), 0);
    chk("reset frame_cnt", int'(frame_cnt), 0);
    chk("reset rd_data", int'(rd_data), 0);
    chk("reset pulses", int'({byte_valid, frame_done, stop_err, short_frame}), 0);
    reset = 1;
    drive(1'b1, 5);

    for (int i = 0; i < 6; i++) begin
      b0 = nbv; e0 = nerr;
      send(tv[i].d, tv[i].ok);
      drive(1'b1, 3);
      @(negedge clk);
      chk($sformatf("vec%0d byte_valid", i), nbv - b0, tv[i].ev);
      chk($sformatf("vec%0d stop_err", i), nerr - e0, tv[i].ee);
      chk($sformatf("vec%0d byte_data", i), int'(byte_data), int'(tv[i].ed));
      chk($sformatf("vec%0d wptr", i), int'(wptr), int'(tv[i].ew));
      @(posedge clk);
      #1;
    end

    s0 = nshort; k = 0;
    while (nshort == s0 && k < 200) begin drive(1'b1, 1); k++; end
    @(negedge clk);
    chk("gap short_frame", nshort - s0, 1);
    chk("gap timing", t_sh - t_bv, GAP);
    chk("gap wptr", int'(wptr), 0);
    chk("gap frame_cnt", int'(frame_cnt), 0);
    @(posedge clk);
    #1;

    b0 = nbv; f0 = nfd; c0 = ncoin;
    for (int i = 0; i < BYTES; i++) send(8'(i * 10), 1'b1);
    drive(1'b1, 3);
    @(negedge clk);
    chk("frame byte_valid", nbv - b0, BYTES);
    chk("frame frame_done", nfd - f0, 1);
    chk("frame coincident", ncoin - c0, 1);
    chk("frame frame_cnt", int'(frame_cnt), 1);
    chk("frame wptr", int'(wptr), 0);
    chk("frame byte_data", int'(byte_data), 190);
    for (int i = 0; i < BYTES; i++) begin
      rd_addr = 5'(i);
      @(negedge clk);
      chk($sformatf("read addr %0d", i), int'(rd_data), i * 10);
    end
    @(posedge clk);
    #1;

    b0 = nbv; e0 = nerr;
    drive(1'b0, 1);
    drive(1'b1, 40);
    @(negedge clk);
    chk("glitch byte_valid", nbv - b0, 0);
    chk("glitch stop_err", nerr - e0, 0);
    chk("glitch wptr", int'(wptr), 0);
    @(posedge clk);
    #1;

    b0 = nbv; e0 = nerr; s0 = nshort;
    drive(1'b0, OVS);
    drive(1'b1, OVS);
    drive(1'b0, 3 * OVS);
    drive(1'b0, OVS / 2);
    reset = 0;
    rx = 1;
    #1;
    chk("midreset byte_data", int'(byte_data), 0);
    chk("midreset frame_cnt", int'(frame_cnt), 0);
    chk("midreset wptr", int'(wptr), 0);
    chk("midreset rd_data", int'(rd_data), 0);
    drive(1'b1, 3);
    reset = 1;
    drive(1'b1, 5);
    send(8'h81, 1'b1);
    drive(1'b1, 3);
    @(negedge clk);
    chk("post-reset byte_valid", nbv - b0, 1);
    chk("post-reset no errors", nerr - e0 + nshort - s0, 0);
    chk("post-reset byte_data", int'(byte_data), 8'h81);
    chk("post-reset wptr", int'(wptr), 1);
    chk("done/short never together", ncoll, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
